// File: rtl/reg_file_cmd_ctrl_pkg.sv
// Shared constants and state encoding for the UART-to-register-file command sequencer.
package reg_file_cmd_ctrl_pkg;

  localparam logic [7:0] OP_WR          = 8'hAA;
  localparam logic [7:0] OP_RD          = 8'hBB;
  localparam int         RD_TIMEOUT_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_TX_SEND = 3'd5
  } state_t;

  function automatic int depth(input int add_w);
    return 2 ** add_w;
  endfunction

endpackage

// File: rtl/reg_file_cmd_ctrl_if.sv
// Bundle of UART RX/TX and register-file signals around the command sequencer.
interface reg_file_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADD_W  = 4
);
  logic [DATA_W-1:0] RX_P_DATA;
  logic              RX_D_VLD;
  logic [DATA_W-1:0] RdData;
  logic              RdData_Valid;
  logic              TX_Busy;
  logic              WrEn;
  logic              RdEn;
  logic [ADD_W-1:0]  Address;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] TX_P_DATA;
  logic              TX_D_VLD;
  logic              Cmd_Err;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err
  );
endinterface

// File: rtl/reg_file_cmd_ctrl.sv
// Parses RX byte frames into register-file write/read strobes and returns read data
// to the UART TX. All outputs come straight from flops.
//
//  state     | meaning
//  S_IDLE    | waiting for an opcode byte
//  S_WR_ADDR | write opcode seen, waiting for address byte
//  S_WR_DATA | address latched, waiting for data byte
//  S_RD_ADDR | read opcode seen, waiting for address byte
//  S_RD_WAIT | RdEn issued, waiting for RdData_Valid or timeout
//  S_TX_SEND | read data captured, waiting for TX_Busy low
module reg_file_cmd_ctrl
  import reg_file_cmd_ctrl_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                ADD_W      = 4,
  parameter logic [DATA_W-1:0] WR_CMD     = DATA_W'(OP_WR),
  parameter logic [DATA_W-1:0] RD_CMD     = DATA_W'(OP_RD),
  parameter int                RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic                Clk,
  input  logic                RST,
  reg_file_cmd_ctrl_if.master bus
);

  localparam int DEPTH = depth(ADD_W);
  localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [ADD_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [DATA_W-1:0] txdata_q, txdata_d;
  logic              wren_q, wren_d;
  logic              rden_q, rden_d;
  logic              txvld_q, txvld_d;
  logic              err_q, err_d;
  logic              addr_ok;

  assign addr_ok = (bus.RX_P_DATA < DATA_W'(DEPTH));

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      txdata_q <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      txvld_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      txdata_q <= txdata_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      txvld_q  <= txvld_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    txdata_d = txdata_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    txvld_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == WR_CMD)      state_d = S_WR_ADDR;
          else if (bus.RX_P_DATA == RD_CMD) state_d = S_RD_ADDR;
        end
      end
      S_WR_ADDR, S_RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          if (!addr_ok) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            addr_d = bus.RX_P_DATA[ADD_W-1:0];
            if (state_q == S_WR_ADDR) begin
              state_d = S_WR_DATA;
            end else begin
              rden_d  = 1'b1;
              timer_d = '0;
              state_d = S_RD_WAIT;
            end
          end
        end
      end
      S_WR_DATA: begin
        if (bus.RX_D_VLD) begin
          wrdata_d = bus.RX_P_DATA;
          wren_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      // timer_q is 0 in the RdEn cycle, so the error decision lands RD_TIMEOUT cycles later
      S_RD_WAIT: begin
        if (bus.RdData_Valid) begin
          txdata_d = bus.RdData;
          state_d  = S_TX_SEND;
        end else if (timer_q == TMR_W'(RD_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (timer_q != TMR_W'(RD_TIMEOUT)) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_TX_SEND: begin
        if (!bus.TX_Busy) begin
          txvld_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.WrEn      = wren_q;
  assign bus.RdEn      = rden_q;
  assign bus.Address   = addr_q;
  assign bus.WrData    = wrdata_q;
  assign bus.TX_P_DATA = txdata_q;
  assign bus.TX_D_VLD  = txvld_q;
  assign bus.Cmd_Err   = err_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Scoreboard bench: stimulus pushes expected strobes, a monitor pops them as the DUT emits them.
module tb_reg_file_cmd_ctrl;

  localparam int EV_WR  = 0;
  localparam int EV_RD  = 1;
  localparam int EV_TX  = 2;
  localparam int EV_ERR = 3;

  typedef struct {
    int         kind;
    logic [3:0] addr;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stub_off = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  ev_t  exp_q[$];
  logic [7:0] mem [16];

  reg_file_cmd_ctrl_if #(.DATA_W(8), .ADD_W(4)) bus ();

  reg_file_cmd_ctrl #(.DATA_W(8), .ADD_W(4)) dut (
    .Clk (clk),
    .RST (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // register-file model: reset values, write on WrEn, read data valid the cycle after RdEn
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      mem[2] <= 8'h81;
      mem[3] <= 8'h20;
      bus.RdData       <= 8'h00;
      bus.RdData_Valid <= 1'b0;
    end else begin
      bus.RdData_Valid <= 1'b0;
      if (bus.WrEn) mem[bus.Address] <= bus.WrData;
      if (bus.RdEn && !stub_off) begin
        bus.RdData       <= mem[bus.Address];
        bus.RdData_Valid <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input logic [3:0] a, input logic [7:0] d, input int c);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic match_ev(input int kind, input logic [3:0] a, input logic [7:0] d);
    ev_t e;
    logic ok;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none (cycle %0d)",
               kind, a, d, cyc);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == kind) && (e.cyc < 0 || e.cyc == cyc);
    if (kind == EV_WR || kind == EV_RD) ok = ok && (e.addr == a);
    if (kind == EV_WR || kind == EV_TX) ok = ok && (e.data == d);
    if (!ok) begin
      n_err++;
      $display("FAIL event: got kind %0d addr %0h data %0h cycle %0d, expected kind %0d addr %0h data %0h cycle %0d",
               kind, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.WrEn || bus.RdEn) check("strobe_exclusive", {31'd0, bus.WrEn & bus.RdEn}, 32'd0);
    if (bus.WrEn)     match_ev(EV_WR, bus.Address, bus.WrData);
    if (bus.RdEn)     match_ev(EV_RD, bus.Address, 8'h00);
    if (bus.TX_D_VLD) match_ev(EV_TX, 4'h0, bus.TX_P_DATA);
    if (bus.Cmd_Err)  match_ev(EV_ERR, 4'h0, 8'h00);
  end

  task automatic drive_byte(input logic [7:0] b, output int c);
    @(negedge clk);
    c = cyc;
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
  endtask

  task automatic end_byte();
    @(negedge clk);
    bus.RX_D_VLD = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int c;
    drive_byte(b, c);
    end_byte();
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
    int c;
    send_byte(8'hAA);
    send_byte(a);
    drive_byte(d, c);
    push(EV_WR, a[3:0], d, c + 1);
    end_byte();
  endtask

  task automatic rd_frame(input logic [7:0] a, input logic [7:0] d, input logic exp_tx);
    int c;
    send_byte(8'hBB);
    drive_byte(a, c);
    push(EV_RD, a[3:0], 8'h00, c + 1);
    if (exp_tx) push(EV_TX, 4'h0, d, -1);
    end_byte();
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int c;
    bus.RX_P_DATA = 8'h00;
    bus.RX_D_VLD  = 1'b0;
    bus.TX_Busy   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_WrEn",      {31'd0, bus.WrEn},     32'd0);
    check("rst_RdEn",      {31'd0, bus.RdEn},     32'd0);
    check("rst_TX_D_VLD",  {31'd0, bus.TX_D_VLD}, 32'd0);
    check("rst_Cmd_Err",   {31'd0, bus.Cmd_Err},  32'd0);
    check("rst_Address",   {28'd0, bus.Address},  32'd0);
    check("rst_WrData",    {24'd0, bus.WrData},   32'd0);
    check("rst_TX_P_DATA", {24'd0, bus.TX_P_DATA}, 32'd0);

    rd_frame(8'h02, 8'h81, 1'b1);
    drain();

    // TX backpressure, with a stray byte that must be dropped while waiting
    bus.TX_Busy = 1'b1;
    rd_frame(8'h03, 8'h20, 1'b0);
    repeat (4) @(negedge clk);
    send_byte(8'hAA);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("bp_TX_P_DATA_hold", {24'd0, bus.TX_P_DATA}, 32'h20);
    end
    @(negedge clk);
    bus.TX_Busy = 1'b0;
    push(EV_TX, 4'h0, 8'h20, cyc + 1);
    @(negedge clk);
    @(negedge clk);
    check("bp_TX_P_DATA_after", {24'd0, bus.TX_P_DATA}, 32'h20);
    drain();

    wr_frame(8'h03, 8'h5C);
    rd_frame(8'h03, 8'h5C, 1'b1);
    drain();
    check("model_reg3", {24'd0, mem[3]}, 32'h5C);

    send_byte(8'hAA);
    drive_byte(8'h12, c);
    push(EV_ERR, 4'h0, 8'h00, c + 1);
    end_byte();
    wr_frame(8'h01, 8'hFF);
    drain();
    rd_frame(8'h01, 8'hFF, 1'b1);
    drain();

    stub_off = 1'b1;
    send_byte(8'hBB);
    drive_byte(8'h05, c);
    push(EV_RD, 4'h5, 8'h00, c + 1);
    push(EV_ERR, 4'h0, 8'h00, c + 9);
    end_byte();
    drain();
    stub_off = 1'b0;
    wr_frame(8'h06, 8'h33);
    drain();

    // reset mid-frame: the partial write must vanish and 77 is an unknown opcode
    send_byte(8'hAA);
    send_byte(8'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h77);
    send_byte(8'h5C);
    repeat (10) @(negedge clk);
    check("midrst_no_events", exp_q.size(), 32'd0);
    rd_frame(8'h04, 8'h00, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
